mk14_key_arbiter: RTL and testbench

Arbitrates key events from two requesters, the LED&KEY front-panel scanner and the IR remote decoder. Events are buffered in a small FIFO and replayed to `mk14_soc` as timed keypad presses on `btn_dn`/`btn_up`/`btn_addr`/`btn_bit`. Each press holds long enough for the SCIOS keyboard scan to see it, then is followed by a release pulse and an inter-key gap. The block sits between the input front-ends and the SoC keypad matrix emulation.

---
 rtl/mk14_key_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mk14_key_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mk14_key_arbiter.sv
// mk14_key_arbiter
//
// Merges key events from the LED&KEY front-panel scanner and the IR remote
// decoder into one stream of timed keypad presses for mk14_soc. Accepted
// events are queued in a small FIFO. Each queued event is replayed as:
//   - a press (btn_dn high for HOLD_CYCLES cycles),
//   - a one-cycle release pulse (btn_up),
//   - an idle gap of GAP_CYCLES cycles,
// so the SCIOS keyboard scan reliably sees every key.
//
// Parameters:
//   HOLD_CYCLES  cycles btn_dn is held per press (>= 1)
//   GAP_CYCLES   idle cycles after the release pulse (>= 0)
//   FIFO_DEPTH   queued events, power of two, >= 2
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset, clears all state
//   panel_valid  front-panel event offered
//   panel_addr   panel keypad row address
//   panel_bit    panel keypad column bit
//   panel_ready  panel event accepted on this edge when high with panel_valid
//   ir_valid     IR event offered
//   ir_addr      IR keypad row address
//   ir_bit       IR keypad column bit
//   ir_ready     IR event accepted on this edge when high with ir_valid
//   btn_dn       level, high for the whole press
//   btn_up       one-cycle release pulse
//   btn_addr     row address of the current key
//   btn_bit      column bit of the current key
//   busy         FSM not idle or FIFO non-empty
module mk14_key_arbiter #(
  parameter int HOLD_CYCLES = 2250,
  parameter int GAP_CYCLES  = 1000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       panel_valid,
  input  logic [2:0] panel_addr,
  input  logic [2:0] panel_bit,
  output logic       panel_ready,
  input  logic       ir_valid,
  input  logic [2:0] ir_addr,
  input  logic [2:0] ir_bit,
  output logic       ir_ready,
  output logic       btn_dn,
  output logic       btn_up,
  output logic [2:0] btn_addr,
  output logic [2:0] btn_bit,
  output logic       busy
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CTR_W      = $clog2(MAX_CYCLES + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [CTR_W-1:0] HOLD_LOAD = CTR_W'(HOLD_CYCLES - 1);
  // With no gap the GAP state is never entered, so the load value is unused.
  localparam logic [CTR_W-1:0] GAP_LOAD  = CTR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE,
    ST_GAP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] next_ctr;

  logic             last_grant_ir;
  logic             grant_panel;
  logic             grant_ir;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [5:0]       push_data;
  logic [5:0]       head;

  logic [5:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Round-robin on ties: the panel wins a tie only if IR took the last grant.
  // Readiness never looks at a same-cycle pop, so a full FIFO blocks both
  // requesters even while the FSM is draining an entry.
  always_comb begin
    grant_panel = panel_valid && (!ir_valid || last_grant_ir);
    grant_ir    = ir_valid && !grant_panel;
    full        = (count == DEPTH_CNT);
    empty       = (count == '0);
    panel_ready = !full && grant_panel;
    ir_ready    = !full && grant_ir;
    push        = (panel_valid && panel_ready) || (ir_valid && ir_ready);
    push_data   = grant_panel ? {panel_addr, panel_bit} : {ir_addr, ir_bit};
  end

  // The tie-break memory only moves on an accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_ir <= 1'b1;
    end else if (push) begin
      last_grant_ir <= grant_ir;
    end
  end

  assign head = mem[rd_ptr];
  assign pop  = (state == ST_IDLE) && !empty;

  // Storage is not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Press sequencer. The counter is loaded with N-1 on entry and the state
  // exits on the cycle it reads zero, giving exactly N cycles per state.
  always_comb begin
    next_state = state;
    next_ctr   = ctr;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          next_state = ST_PRESS;
          next_ctr   = HOLD_LOAD;
        end
      end
      ST_PRESS: begin
        if (ctr == '0) begin
          next_state = ST_RELEASE;
        end else begin
          next_ctr = ctr - CTR_W'(1);
        end
      end
      ST_RELEASE: begin
        if (GAP_CYCLES == 0) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_GAP;
          next_ctr   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (ctr == '0) begin
          next_state = ST_IDLE;
        end else begin
          next_ctr = ctr - CTR_W'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // btn_dn/btn_up are decoded from the next state into flops so that they
  // are glitch-free and can never be high together. The key code is only
  // captured on the IDLE->PRESS edge and is held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ctr      <= '0;
      btn_dn   <= 1'b0;
      btn_up   <= 1'b0;
      btn_addr <= 3'd0;
      btn_bit  <= 3'd0;
    end else begin
      state  <= next_state;
      ctr    <= next_ctr;
      btn_dn <= (next_state == ST_PRESS);
      btn_up <= (next_state == ST_RELEASE);
      if (pop) begin
        {btn_addr, btn_bit} <= head;
      end
    end
  end

  assign busy = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_mk14_key_arbiter.sv
// Self-checking bench for mk14_key_arbiter. Instance "dut" uses the
// production timing (2250/1000, depth 4) and is watched by a scoreboard
// monitor; instance "dut_nogap" uses a short hold and no gap.
module tb_mk14_key_arbiter;

  localparam int HOLD   = 2250;
  localparam int GAP    = 1000;
  localparam int DEPTH  = 4;
  localparam int PERIOD = HOLD + GAP + 2;
  localparam int B_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       panel_valid = 1'b0;
  logic [2:0] panel_addr  = 3'd0;
  logic [2:0] panel_bit   = 3'd0;
  logic       panel_ready;
  logic       ir_valid    = 1'b0;
  logic [2:0] ir_addr     = 3'd0;
  logic [2:0] ir_bit      = 3'd0;
  logic       ir_ready;
  logic       btn_dn;
  logic       btn_up;
  logic [2:0] btn_addr;
  logic [2:0] btn_bit;
  logic       busy;

  logic       b_panel_valid = 1'b0;
  logic [2:0] b_panel_addr  = 3'd0;
  logic [2:0] b_panel_bit   = 3'd0;
  logic       b_panel_ready;
  logic       b_ir_valid    = 1'b0;
  logic [2:0] b_ir_addr     = 3'd0;
  logic [2:0] b_ir_bit      = 3'd0;
  logic       b_ir_ready;
  logic       b_btn_dn;
  logic       b_btn_up;
  logic [2:0] b_btn_addr;
  logic [2:0] b_btn_bit;
  logic       b_busy;

  mk14_key_arbiter #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .panel_valid(panel_valid),
    .panel_addr (panel_addr),
    .panel_bit  (panel_bit),
    .panel_ready(panel_ready),
    .ir_valid   (ir_valid),
    .ir_addr    (ir_addr),
    .ir_bit     (ir_bit),
    .ir_ready   (ir_ready),
    .btn_dn     (btn_dn),
    .btn_up     (btn_up),
    .btn_addr   (btn_addr),
    .btn_bit    (btn_bit),
    .busy       (busy)
  );

  mk14_key_arbiter #(
    .HOLD_CYCLES(B_HOLD),
    .GAP_CYCLES (0),
    .FIFO_DEPTH (DEPTH)
  ) dut_nogap (
    .clk        (clk),
    .rst        (rst),
    .panel_valid(b_panel_valid),
    .panel_addr (b_panel_addr),
    .panel_bit  (b_panel_bit),
    .panel_ready(b_panel_ready),
    .ir_valid   (b_ir_valid),
    .ir_addr    (b_ir_addr),
    .ir_bit     (b_ir_bit),
    .ir_ready   (b_ir_ready),
    .btn_dn     (b_btn_dn),
    .btn_up     (b_btn_up),
    .btn_addr   (b_btn_addr),
    .btn_bit    (b_btn_bit),
    .busy       (b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         press_count  = 0;
  logic [5:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic waitEdge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst           = 1'b1;
    panel_valid   = 1'b0;
    ir_valid      = 1'b0;
    b_panel_valid = 1'b0;
    exp_q.delete();
    waitEdge(3);
    rst = 1'b0;
  endtask

  // One handshake on the main instance; waits up to budget cycles for ready.
  task automatic applyStimulus(input bit is_ir, input logic [5:0] code,
                               input int budget, output int acc_cyc);
    int   waited;
    logic rdy;
    waited = 0;
    if (is_ir) begin
      ir_valid = 1'b1;
      {ir_addr, ir_bit} = code;
    end else begin
      panel_valid = 1'b1;
      {panel_addr, panel_bit} = code;
    end
    @(negedge clk);
    rdy = is_ir ? ir_ready : panel_ready;
    while (!rdy && waited < budget) begin
      @(negedge clk);
      waited++;
      rdy = is_ir ? ir_ready : panel_ready;
    end
    if (!rdy) begin
      checkOutput("ready_timeout", 0, 1);
      acc_cyc = -1;
    end else begin
      exp_q.push_back(code);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    if (is_ir) ir_valid = 1'b0;
    else panel_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int w;
    w = 0;
    while ((busy || exp_q.size() != 0) && w < budget) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_timeout", 32'(busy || exp_q.size() != 0), 0);
    waitEdge(1);
  endtask

  // Scoreboard monitor for the main instance.
  initial begin
    logic       prev_dn;
    int         dn_len;
    int         prev_start;
    logic [5:0] cur_code;
    prev_dn    = 1'b0;
    dn_len     = 0;
    prev_start = -1;
    cur_code   = 6'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dn    = 1'b0;
        dn_len     = 0;
        prev_start = -1;
      end else begin
        if (btn_dn && !prev_dn) begin
          press_count++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_press", 1, 0);
          end else begin
            cur_code = exp_q.pop_front();
            checkOutput("press_code", 32'({btn_addr, btn_bit}), 32'(cur_code));
          end
          if (prev_start >= 0) checkOutput("key_period", cyc - prev_start, PERIOD);
          prev_start = cyc;
        end
        if (btn_dn) dn_len++;
        if (!btn_dn && prev_dn) begin
          checkOutput("hold_len", dn_len, HOLD);
          checkOutput("up_after_dn", 32'(btn_up), 1);
          dn_len = 0;
        end
        if (btn_up) begin
          checkOutput("up_follows_dn", 32'(prev_dn), 1);
          checkOutput("up_code", 32'({btn_addr, btn_bit}), 32'(cur_code));
        end
        if (!busy) prev_start = -1;
        prev_dn = btn_dn;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         e0;
    int         acc;
    int         start;
    logic [5:0] pc;
    logic [5:0] ic;
    bit         saw;

    doReset();
    checkOutput("rst_btn_dn", 32'(btn_dn), 0);
    checkOutput("rst_btn_up", 32'(btn_up), 0);
    checkOutput("rst_btn_code", 32'({btn_addr, btn_bit}), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ready_idle", 32'({panel_ready, ir_ready}), 0);

    // Single panel key (1,4)
    $display("[TB] single panel key");
    applyStimulus(1'b0, 6'o14, 2, e0);
    checkOutput("t1_no_dn_at_E", 32'(btn_dn), 0);
    checkOutput("t1_busy_at_E", 32'(busy), 1);
    waitEdge(1);
    checkOutput("t1_dn_start", 32'(btn_dn), 1);
    checkOutput("t1_code", 32'({btn_addr, btn_bit}), 32'(6'o14));
    waitEdge(HOLD - 1);
    checkOutput("t1_dn_last", 32'({btn_dn, btn_up}), 32'(2'b10));
    waitEdge(1);
    checkOutput("t1_up_pulse", 32'({btn_dn, btn_up}), 32'(2'b01));
    waitEdge(1);
    checkOutput("t1_up_end", 32'({btn_up, busy}), 32'(2'b01));
    waitEdge(GAP - 1);
    checkOutput("t1_busy_gap_end", 32'(busy), 1);
    waitEdge(1);
    checkOutput("t1_busy_drop", 32'(busy), 0);
    checkOutput("t1_queue_empty", exp_q.size(), 0);

    // Simultaneous request on the first cycle after reset
    $display("[TB] simultaneous request");
    doReset();
    start = press_count;
    panel_valid = 1'b1; {panel_addr, panel_bit} = 6'o07;
    ir_valid    = 1'b1; {ir_addr, ir_bit}       = 6'o25;
    @(negedge clk);
    checkOutput("t2_tie_panel", 32'({panel_ready, ir_ready}), 32'(2'b10));
    exp_q.push_back(6'o07);
    waitEdge(1);
    panel_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_then_ir", 32'({panel_ready, ir_ready}), 32'(2'b01));
    exp_q.push_back(6'o25);
    waitEdge(1);
    ir_valid = 1'b0;
    waitIdle(3 * PERIOD);
    checkOutput("t2_presses", press_count - start, 2);

    // Continuous contention with incrementing codes
    $display("[TB] continuous contention");
    doReset();
    start = press_count;
    pc = 6'o11;
    ic = 6'o62;
    panel_valid = 1'b1; {panel_addr, panel_bit} = pc;
    ir_valid    = 1'b1; {ir_addr, ir_bit}       = ic;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t3_panel_ready", 32'(panel_ready), 32'(k % 2 == 0));
      checkOutput("t3_ir_ready", 32'(ir_ready), 32'(k % 2 == 1));
      if (k % 2 == 0) exp_q.push_back(pc);
      else exp_q.push_back(ic);
      waitEdge(1);
      if (k % 2 == 0) begin
        pc = pc + 6'd1;
        {panel_addr, panel_bit} = pc;
      end else begin
        ic = ic + 6'd1;
        {ir_addr, ir_bit} = ic;
      end
    end
    panel_valid = 1'b0;
    ir_valid    = 1'b0;
    waitIdle(5 * PERIOD);
    checkOutput("t3_presses", press_count - start, 4);

    // Backpressure: five accepts fill the FIFO, the sixth waits for a pop
    $display("[TB] backpressure");
    doReset();
    start = press_count;
    applyStimulus(1'b0, 6'o40, 2, e0);
    for (int k = 1; k < 5; k++) begin
      applyStimulus(1'b0, 6'o40 + 6'(k), 2, acc);
      checkOutput("t4_accept_cycle", acc - e0, k);
    end
    panel_valid = 1'b1;
    {panel_addr, panel_bit} = 6'o77;
    @(negedge clk);
    checkOutput("t4_full_ready", 32'(panel_ready), 0);
    checkOutput("t4_full_busy", 32'(busy), 1);
    applyStimulus(1'b0, 6'o77, PERIOD + 10, acc);
    checkOutput("t4_accept_after_pop", acc - e0, PERIOD + 2);
    waitIdle(7 * PERIOD);
    checkOutput("t4_presses", press_count - start, 6);

    // Reset in the middle of a press with two events queued
    $display("[TB] reset mid-press");
    doReset();
    applyStimulus(1'b0, 6'o01, 2, e0);
    applyStimulus(1'b0, 6'o02, 2, acc);
    applyStimulus(1'b0, 6'o03, 2, acc);
    waitEdge(HOLD / 2);
    checkOutput("t5_in_press", 32'(btn_dn), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_dn", 32'({btn_dn, btn_up}), 0);
    checkOutput("t5_async_busy", 32'(busy), 0);
    checkOutput("t5_async_code", 32'({btn_addr, btn_bit}), 0);
    exp_q.delete();
    waitEdge(3);
    rst = 1'b0;
    saw = 1'b0;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      if (btn_dn || btn_up) saw = 1'b1;
    end
    checkOutput("t5_no_activity", 32'(saw), 0);
    checkOutput("t5_busy_after", 32'(busy), 0);

    // No gap: release pulse, one idle cycle, then the next key
    $display("[TB] zero gap, two keys");
    doReset();
    b_panel_valid = 1'b1;
    {b_panel_addr, b_panel_bit} = 6'o31;
    @(negedge clk);
    checkOutput("t6_ready_1", 32'(b_panel_ready), 1);
    waitEdge(1);
    {b_panel_addr, b_panel_bit} = 6'o56;
    @(negedge clk);
    checkOutput("t6_ready_2", 32'(b_panel_ready), 1);
    waitEdge(1);
    b_panel_valid = 1'b0;
    checkOutput("t6_first_dn", 32'({b_btn_dn, b_btn_addr, b_btn_bit}), 32'({1'b1, 6'o31}));
    waitEdge(B_HOLD - 1);
    checkOutput("t6_first_dn_last", 32'({b_btn_dn, b_btn_up}), 32'(2'b10));
    waitEdge(1);
    checkOutput("t6_first_up", 32'({b_btn_dn, b_btn_up, b_btn_addr, b_btn_bit}), 32'({2'b01, 6'o31}));
    waitEdge(1);
    checkOutput("t6_idle_gap", 32'({b_btn_dn, b_btn_up, b_btn_addr, b_btn_bit}), 32'({2'b00, 6'o31}));
    checkOutput("t6_idle_busy", 32'(b_busy), 1);
    waitEdge(1);
    checkOutput("t6_second_dn", 32'({b_btn_dn, b_btn_addr, b_btn_bit}), 32'({1'b1, 6'o56}));
    waitEdge(B_HOLD);
    checkOutput("t6_second_up", 32'({b_btn_dn, b_btn_up}), 32'(2'b01));
    waitEdge(1);
    checkOutput("t6_done", 32'({b_btn_up, b_busy}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
